// File: rtl/nibble_add_seq.sv
// Purpose: 16-bit adder built from one shared 4-bit nibble adder, one nibble per cycle (optional subtract: ADDSEQ_SUB_EN).
// Latency: done pulses 4 edges after the accepting start edge; one operation per 6 cycles.
// Backpressure: start is taken only in IDLE; start while busy or done is dropped, never queued.
module nibble_add_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
`ifdef ADDSEQ_SUB_EN
    input  logic        sub,
`endif
    output logic        busy,
    output logic        done,
    output logic [16:0] s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] work;
    logic        carry;
    logic [1:0]  idx;

    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [4:0]  nib;

    // Shared nibble adder: operand slice selected by the current nibble index.
    always_comb begin
        a_nib = a_reg[{idx, 2'b00} +: 4];
        b_nib = b_reg[{idx, 2'b00} +: 4];
        nib   = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, nibble accumulation and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= 16'h0000;
            b_reg <= 16'h0000;
            work  <= 16'h0000;
            carry <= 1'b0;
            idx   <= 2'd0;
            s     <= 17'h00000;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        idx   <= 2'd0;
`ifdef ADDSEQ_SUB_EN
                        // Two's-complement subtract: invert b and force the carry-in.
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
`else
                        b_reg <= b;
                        carry <= cin;
`endif
                    end
                end
                RUN: begin
                    work[{idx, 2'b00} +: 4] <= nib[3:0];
                    carry                   <= nib[4];
                    idx                     <= idx + 2'd1;
                    // Publish only the complete sum so s never shows a partial result.
                    if (idx == 2'd3) begin
                        s <= {nib[4], nib[3:0], work[11:0]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Purpose: directed self-checking bench for nibble_add_seq (sub tests built when ADDSEQ_SUB_EN is defined).
// Latency: expects done 4 edges after accept and a 6-cycle operation period.
// Backpressure: exercises start held during RUN/DONE, which must be ignored.
`timescale 1ns/1ps
module tb_nibble_add_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
`ifdef ADDSEQ_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [16:0] s;

    int n_cmp;
    int n_fail;

    nibble_add_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef ADDSEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and observe 8 cycles after the accepting edge.
    task automatic do_op(input logic [15:0] aa, input logic [15:0] bb, input logic cc,
                         output int lat, output logic [16:0] res, output int npulse,
                         output int nbusy);
        lat    = -1;
        res    = 17'h0;
        npulse = 0;
        nbusy  = 0;
        a      = aa;
        b      = bb;
        cin    = cc;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        a      = 16'hDEAD;
        b      = 16'hBEEF;
        if (busy) nbusy++;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (busy) nbusy++;
            if (done) begin
                npulse++;
                if (lat < 0) begin
                    lat = k;
                    res = s;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = 16'h0;
        b     = 16'h0;
        cin   = 1'b0;
`ifdef ADDSEQ_SUB_EN
        sub   = 1'b0;
`endif
        tick();
        tick();
        n_cmp++;
        if ({s, busy, done} !== {17'h00000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: s=%h busy=%b done=%b, want s=00000 busy=0 done=0", s, busy, done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_add();
        int lat, np, nb;
        logic [16:0] r;
        do_op(16'h1234, 16'h4321, 1'b0, lat, r, np, nb);
        n_cmp++;
        if (r !== 17'h05555) begin
            n_fail++;
            $display("FAIL basic_add_sum: got %h want 05555", r);
        end
        n_cmp++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_add_latency: got %0d want 4", lat);
        end
        n_cmp++;
        if (nb !== 4) begin
            n_fail++;
            $display("FAIL basic_add_busy_cycles: got %0d want 4", nb);
        end
        n_cmp++;
        if (np !== 1) begin
            n_fail++;
            $display("FAIL basic_add_pulses: got %0d want 1", np);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 20; i++) begin
            tick();
            n_cmp++;
            if (s !== 17'h05555 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL s_hold[%0d]: s=%h done=%b, want s=05555 done=0", i, s, done);
            end
        end
    endtask

    task automatic test_full_carry();
        int lat, np, nb;
        logic [16:0] r;
        do_op(16'hFFFF, 16'h0001, 1'b0, lat, r, np, nb);
        n_cmp++;
        if (r !== 17'h10000 || lat !== 4) begin
            n_fail++;
            $display("FAIL ripple_ffff_1: s=%h lat=%0d, want s=10000 lat=4", r, lat);
        end
        do_op(16'hFFFF, 16'hFFFF, 1'b1, lat, r, np, nb);
        n_cmp++;
        if (r !== 17'h1FFFF || lat !== 4) begin
            n_fail++;
            $display("FAIL ripple_ffff_ffff_c: s=%h lat=%0d, want s=1FFFF lat=4", r, lat);
        end
        do_op(16'h8000, 16'h8000, 1'b1, lat, r, np, nb);
        n_cmp++;
        if (r !== 17'h10001) begin
            n_fail++;
            $display("FAIL top_nibble_carry: s=%h want 10001", r);
        end
    endtask

    task automatic test_reset_mid();
        int np;
        a     = 16'h1234;
        b     = 16'h4321;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({s, busy, done} !== {17'h00000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_run: s=%h busy=%b done=%b, want s=00000 busy=0 done=0", s, busy, done);
        end
        tick();
        rst = 1'b0;
        np  = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done) np++;
        end
        n_cmp++;
        if (np !== 0 || s !== 17'h00000) begin
            n_fail++;
            $display("FAIL reset_no_done: pulses=%0d s=%h, want pulses=0 s=00000", np, s);
        end
    endtask

    task automatic test_after_reset();
        int lat, np, nb;
        logic [16:0] r;
        do_op(16'h0001, 16'h0002, 1'b0, lat, r, np, nb);
        n_cmp++;
        if (r !== 17'h00003 || lat !== 4 || np !== 1) begin
            n_fail++;
            $display("FAIL post_reset_op: s=%h lat=%0d pulses=%0d, want s=00003 lat=4 pulses=1", r, lat, np);
        end
    endtask

    task automatic test_ignored_start();
        int np;
        np    = 0;
        a     = 16'h0001;
        b     = 16'h0001;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        a = 16'h00FF;
        for (int k = 1; k <= 4; k++) begin
            b   = (k[0]) ? 16'hABCD : 16'h1357;
            cin = k[0];
            tick();
            if (done) np++;
        end
        n_cmp++;
        if (done !== 1'b1 || s !== 17'h00002) begin
            n_fail++;
            $display("FAIL ignored_start_result: done=%b s=%h, want done=1 s=00002", done, s);
        end
        b   = 16'h0001;
        cin = 1'b0;
        tick();
        if (done) np++;
        n_cmp++;
        if (np !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_pulses: pulses=%0d busy=%b, want pulses=1 busy=0", np, busy);
        end
        tick();
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_at_e6: busy=%b want 1", busy);
        end
        a = 16'h0000;
        b = 16'h0000;
        for (int k = 1; k <= 4; k++) tick();
        n_cmp++;
        if (done !== 1'b1 || s !== 17'h00100) begin
            n_fail++;
            $display("FAIL e6_op_result: done=%b s=%h, want done=1 s=00100", done, s);
        end
        tick();
    endtask

`ifdef ADDSEQ_SUB_EN
    task automatic test_sub();
        int lat, np, nb;
        logic [16:0] r;
        sub = 1'b1;
        do_op(16'h0005, 16'h0003, 1'b0, lat, r, np, nb);
        n_cmp++;
        if (r !== 17'h10002) begin
            n_fail++;
            $display("FAIL sub_5_3: s=%h want 10002", r);
        end
        do_op(16'h0003, 16'h0005, 1'b0, lat, r, np, nb);
        n_cmp++;
        if (r !== 17'h0FFFE) begin
            n_fail++;
            $display("FAIL sub_3_5: s=%h want 0FFFE", r);
        end
        do_op(16'h0005, 16'h0003, 1'b1, lat, r, np, nb);
        n_cmp++;
        if (r !== 17'h10002) begin
            n_fail++;
            $display("FAIL sub_cin_ignored: s=%h want 10002", r);
        end
        sub = 1'b0;
        do_op(16'h0005, 16'h0003, 1'b1, lat, r, np, nb);
        n_cmp++;
        if (r !== 17'h00009) begin
            n_fail++;
            $display("FAIL sub0_add: s=%h want 00009", r);
        end
    endtask
`endif

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_basic_add();
        test_hold();
        test_full_carry();
        test_basic_add();
        test_reset_mid();
        test_after_reset();
        test_ignored_start();
`ifdef ADDSEQ_SUB_EN
        test_sub();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

- Sequential 16-bit adder controller that time-shares one 4-bit nibble adder datapath ({c,s} = a_n + b_n + c_in, 5-bit result) across four clock cycles.
- A registered carry chains the nibbles; a start/busy/done handshake frames each operation.
- Sits between the lab top level (switches/registers supplying operands) and the display path that consumes the 17-bit result.

## Interface
Parameters: none (operand width fixed at 16 bits, 4 nibbles).

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  16  operand A; captured on accepted start
- b  in  16  operand B; captured on accepted start
- cin  in  1  carry-in; captured on accepted start
- sub  in  1  subtract select; present only with ADDSEQ_SUB_EN; captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; result valid
- s  out  17  result, {carry_out, sum[15:0]}

## Operation
- Reset values (rst=1 at an edge) apply regardless of state, including mid-operation:
  - state = IDLE
  - s = 0, busy = 0, done = 0
  - internal carry, nibble index, operand registers = 0
  - An operation interrupted by reset never pulses done.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start = 1: latch a, b, cin into operand registers; carry := cin; idx := 0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy = 1), each cycle:
  - nibble adder inputs: a_reg[4*idx+3:4*idx], b_reg[4*idx+3:4*idx], carry.
  - Write the 4-bit sum into working register bits [4*idx+3:4*idx].
  - carry := nibble carry-out; idx := idx + 1.
  - After idx = 3 is processed, go to DONE.
- DONE:
  - s := {carry, working[15:0]}, registered on the DONE entry edge.
  - done = 1 for exactly this cycle; next state is IDLE.
- start in RUN or DONE is ignored; it is not queued. Operand inputs may change freely after acceptance.
- s holds its value from DONE until the next DONE or reset. It never shows partial sums.
- Arithmetic: unsigned; s = a + b + cin, full 17-bit, no overflow loss.

## Timing
- Edge E0: start sampled high in IDLE.
- Edges E1..E4: nibbles 0..3 processed. E4 enters DONE.
- Cycle after E4: done = 1, s valid. busy = 1 between E0 and E4, 0 from E4.
- E5: back to IDLE. Earliest next accepted start is at E6.
- Throughput: one operation per 6 cycles.
- Latency: done is asserted 4 edges after the accepting edge.

## Configuration
- ADDSEQ_SUB_EN defined:
  - The sub port exists.
  - With sub = 1 on accept, b_reg := ~b and carry := 1 (cin ignored), so s = a + ~b + 1.
  - s[16] = 1 means no borrow (a ≥ b).
  - With sub = 0, behaviour is identical to the add-only build.
- ADDSEQ_SUB_EN undefined:
  - No sub port; add only.
  - Logic and ports for subtraction are absent.

## Test plan
- Reset: rst = 1 for 2 cycles during RUN with a = 0x1234 → s = 0x00000, busy = 0, done = 0 after the edge; done never pulses; next start works normally.
- Basic add: a = 0x1234, b = 0x4321, cin = 0, start one cycle → busy for 4 cycles, done pulses 4 edges after accept, s = 0x05555.
- Full carry ripple: a = 0xFFFF, b = 0x0001, cin = 0 → s = 0x10000. Then a = 0xFFFF, b = 0xFFFF, cin = 1 → s = 0x1FFFF.
- Ignored start: accept a = 0x0001, b = 0x0001. Assert start with a = 0x00FF during RUN and DONE, changing inputs → s = 0x00002; only one done pulse. Then start is accepted at E6.
- s hold: after a result of 0x05555, leave start low for 20 cycles → s stays 0x05555, done stays 0.
- With ADDSEQ_SUB_EN:
  - sub = 1, a = 0x0005, b = 0x0003 → s = 0x10002.
  - a = 0x0003, b = 0x0005 → s = 0x0FFFE.
  - cin = 1 has no effect while sub = 1.
